// File: rtl/router_output_arbiter_if.sv
// Bundle between router input stages (master) and one output-port arbiter (slave).
// Handshake: si is a one-cycle push strobe into slot i and is dropped while busy[i]=1;
// ready is sampled at the launching edge, and every so=1 pulse is an accepted packet (no retry).
interface router_output_arbiter_if #(
  parameter int PKTWIDTH = 64,
  parameter int NPORTS   = 5,
  parameter int CNTW     = 16
);
  logic [NPORTS*PKTWIDTH-1:0] datain;
  logic [NPORTS-1:0]          si;
  logic [NPORTS-1:0]          busy;
  logic                       ready;
  logic [PKTWIDTH-1:0]        dataout;
  logic                       so;
  logic [NPORTS-1:0]          grant;
  logic [CNTW-1:0]            drop_cnt;

  modport master (
    output datain, si, ready,
    input  busy, dataout, so, grant, drop_cnt
  );

  modport slave (
    input  datain, si, ready,
    output busy, dataout, so, grant, drop_cnt
  );
endinterface

// File: rtl/router_output_arbiter.sv
// Round-robin arbiter draining one-packet holding slots of NPORTS requesters onto
// a single router output link, one packet per cycle while downstream is ready.
module router_output_arbiter #(
  parameter int PKTWIDTH = 64,
  parameter int NPORTS   = 5,
  parameter int CNTW     = 16,
  localparam int PW      = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  router_output_arbiter_if.slave bus,
  output logic [PW-1:0]         o_dbg_rr_ptr
);
  localparam int SUMW = CNTW + PW + 1;

  logic [PKTWIDTH-1:0] r_slot [NPORTS];
  logic [NPORTS-1:0]   r_full;
  logic [PW-1:0]       r_rr_ptr;
  logic [PKTWIDTH-1:0] r_dataout;
  logic                r_so;
  logic [NPORTS-1:0]   r_grant;
  logic [CNTW-1:0]     r_drop_cnt;

  logic [PW:0]         w_cand;
  logic [PW-1:0]       w_win;
  logic                w_found;
  logic                w_fire;
  logic [PW-1:0]       w_next_ptr;
  logic [NPORTS-1:0]   w_cap;
  logic [NPORTS-1:0]   w_drop;
  logic [PW:0]         w_drop_n;
  logic [SUMW-1:0]     w_cnt_sum;
  logic [CNTW-1:0]     w_cnt_next;

  always_comb begin
    w_cand  = '0;
    w_win   = '0;
    w_found = 1'b0;
    // Scan full slots starting at rr_ptr, wrapping modulo NPORTS.
    for (int k = 0; k < NPORTS; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (PW+1)'(k);
      if (w_cand >= (PW+1)'(NPORTS)) w_cand = w_cand - (PW+1)'(NPORTS);
      if (!w_found && r_full[w_cand[PW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_cand[PW-1:0];
      end
    end
    w_fire     = bus.ready && w_found;
    w_next_ptr = (w_win == PW'(NPORTS-1)) ? '0 : w_win + PW'(1);

    // A strobe into a full slot is lost, even if that slot drains this cycle.
    w_cap    = bus.si & ~r_full;
    w_drop   = bus.si & r_full;
    w_drop_n = '0;
    for (int i = 0; i < NPORTS; i++) w_drop_n = w_drop_n + (PW+1)'(w_drop[i]);
    w_cnt_sum  = SUMW'(r_drop_cnt) + SUMW'(w_drop_n);
    w_cnt_next = (w_cnt_sum > SUMW'({CNTW{1'b1}})) ? '1 : w_cnt_sum[CNTW-1:0];
  end

  // Slot storage carries no reset; validity is tracked solely by r_full.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NPORTS; i++) begin
      if (w_cap[i]) r_slot[i] <= bus.datain[i*PKTWIDTH +: PKTWIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_full     <= '0;
      r_rr_ptr   <= '0;
      r_dataout  <= '0;
      r_so       <= 1'b0;
      r_grant    <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_drop_cnt <= w_cnt_next;
      r_so       <= w_fire;
      r_grant    <= '0;
      for (int i = 0; i < NPORTS; i++) begin
        if (w_cap[i]) r_full[i] <= 1'b1;
      end
      if (w_fire) begin
        r_dataout      <= r_slot[w_win];
        r_grant        <= NPORTS'(1) << w_win;
        r_full[w_win]  <= 1'b0;
        r_rr_ptr       <= w_next_ptr;
      end
    end
  end

  assign bus.busy      = r_full;
  assign bus.dataout   = r_dataout;
  assign bus.so        = r_so;
  assign bus.grant     = r_grant;
  assign bus.drop_cnt  = r_drop_cnt;
  assign o_dbg_rr_ptr  = r_rr_ptr;
endmodule

// File: tb/tb_router_output_arbiter.sv
// Bench for router_output_arbiter: directed table, corner sequences and random traffic
// against a slot/queue model; a CNTW=2 copy shares the inputs to observe saturation.
module tb_router_output_arbiter;
  localparam int PKTW = 64;
  localparam int NP   = 5;

  typedef struct {
    logic          rst_n;
    logic [NP-1:0] si;
    logic          ready;
    logic [NP-1:0] x_busy;
    logic          x_so;
    logic [NP-1:0] x_grant;
    logic [63:0]   x_data;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic [2:0] dbg16;
  logic [2:0] dbg2;

  always #5 clk = ~clk;

  router_output_arbiter_if #(.PKTWIDTH(PKTW), .NPORTS(NP), .CNTW(16)) bus ();
  router_output_arbiter_if #(.PKTWIDTH(PKTW), .NPORTS(NP), .CNTW(2))  bus2 ();

  assign bus2.datain = bus.datain;
  assign bus2.si     = bus.si;
  assign bus2.ready  = bus.ready;

  router_output_arbiter #(.PKTWIDTH(PKTW), .NPORTS(NP), .CNTW(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .o_dbg_rr_ptr(dbg16)
  );

  router_output_arbiter #(.PKTWIDTH(PKTW), .NPORTS(NP), .CNTW(2)) dut_sat (
    .clk(clk), .reset(reset), .bus(bus2), .o_dbg_rr_ptr(dbg2)
  );

  // ---------------- scoreboard / model ----------------
  int n_cmp = 0;
  int n_err = 0;

  logic [NP-1:0] full_m = '0;
  logic [63:0]   slot_m [NP];
  int            rr_m   = 0;
  int            drop_m = 0;
  logic          exp_so = 1'b0;
  logic [NP-1:0] exp_grant = '0;
  logic [63:0]   exp_data  = '0;
  logic [63:0]   exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Applies the block's rules to the inputs present just before a rising edge.
  task automatic model_edge();
    logic [NP-1:0] fb;
    int w;
    if (!reset) begin
      full_m    = '0;
      rr_m      = 0;
      drop_m    = 0;
      exp_so    = 1'b0;
      exp_grant = '0;
      exp_data  = '0;
      exp_q.delete();
    end else begin
      fb        = full_m;
      exp_so    = 1'b0;
      exp_grant = '0;
      w         = -1;
      if (bus.ready) begin
        for (int k = 0; k < NP; k++) begin
          if (w < 0 && fb[(rr_m + k) % NP]) w = (rr_m + k) % NP;
        end
      end
      if (w >= 0) begin
        exp_so       = 1'b1;
        exp_grant[w] = 1'b1;
        exp_data     = slot_m[w];
        exp_q.push_back(slot_m[w]);
        full_m[w]    = 1'b0;
        rr_m         = (w + 1) % NP;
      end
      for (int i = 0; i < NP; i++) begin
        if (bus.si[i]) begin
          if (fb[i]) drop_m++;
          else begin
            slot_m[i] = bus.datain[i*PKTW +: PKTW];
            full_m[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_model();
    logic [63:0] sat16;
    logic [63:0] sat2;
    sat16 = (drop_m > 65535) ? 64'd65535 : 64'(drop_m);
    sat2  = (drop_m > 3) ? 64'd3 : 64'(drop_m);
    chk("m_busy", 64'(bus.busy), 64'(full_m));
    chk("m_so", 64'(bus.so), 64'(exp_so));
    chk("m_grant", 64'(bus.grant), 64'(exp_grant));
    chk("m_dataout", bus.dataout, exp_data);
    chk("m_drop16", 64'(bus.drop_cnt), sat16);
    chk("m_drop2", 64'(bus2.drop_cnt), sat2);
    chk("m_rr_ptr", 64'(dbg16), 64'(rr_m));
    chk("m_grant2", 64'(bus2.grant), 64'(exp_grant));
    if (bus.so === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_extra_pkt", 64'd1, 64'd0);
      else chk("sb_pkt", bus.dataout, exp_q.pop_front());
    end
  endtask

  // ---------------- driver ----------------
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  function automatic logic [63:0] pkt(input int i);
    return {16'h4000 + 16'(i), 16'hBEEF, 32'(i)};
  endfunction

  function automatic vec_t mk(input logic r, input logic [NP-1:0] s, input logic rd,
                              input logic [NP-1:0] xb, input logic xs,
                              input logic [NP-1:0] xg, input int port);
    vec_t v;
    v.rst_n = r; v.si = s; v.ready = rd;
    v.x_busy = xb; v.x_so = xs; v.x_grant = xg;
    v.x_data = (port >= 0) ? pkt(port) : 64'd0;
    return v;
  endfunction

  task automatic load_pkts();
    for (int i = 0; i < NP; i++) bus.datain[i*PKTW +: PKTW] = pkt(i);
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl [20];

  initial begin
    // Round-robin from rr=0, move rr to 4 via port 3, then 4-before-0 wrap, then 1/3 alternation.
    tbl[0]  = mk(1, 5'h1F, 0, 5'h1F, 0, 5'h00, -1);
    tbl[1]  = mk(1, 5'h00, 1, 5'h1E, 1, 5'h01, 0);
    tbl[2]  = mk(1, 5'h00, 1, 5'h1C, 1, 5'h02, 1);
    tbl[3]  = mk(1, 5'h00, 1, 5'h18, 1, 5'h04, 2);
    tbl[4]  = mk(1, 5'h00, 1, 5'h10, 1, 5'h08, 3);
    tbl[5]  = mk(1, 5'h00, 1, 5'h00, 1, 5'h10, 4);
    tbl[6]  = mk(1, 5'h00, 1, 5'h00, 0, 5'h00, -1);
    tbl[7]  = mk(1, 5'h08, 0, 5'h08, 0, 5'h00, -1);
    tbl[8]  = mk(1, 5'h00, 1, 5'h00, 1, 5'h08, 3);
    tbl[9]  = mk(1, 5'h11, 0, 5'h11, 0, 5'h00, -1);
    tbl[10] = mk(1, 5'h00, 1, 5'h01, 1, 5'h10, 4);
    tbl[11] = mk(1, 5'h00, 1, 5'h00, 1, 5'h01, 0);
    tbl[12] = mk(1, 5'h0A, 0, 5'h0A, 0, 5'h00, -1);
    tbl[13] = mk(1, 5'h00, 1, 5'h08, 1, 5'h02, 1);
    tbl[14] = mk(1, 5'h02, 1, 5'h02, 1, 5'h08, 3);
    tbl[15] = mk(1, 5'h08, 1, 5'h08, 1, 5'h02, 1);
    tbl[16] = mk(1, 5'h02, 1, 5'h02, 1, 5'h08, 3);
    tbl[17] = mk(1, 5'h08, 1, 5'h08, 1, 5'h02, 1);
    tbl[18] = mk(1, 5'h00, 1, 5'h00, 1, 5'h08, 3);
    tbl[19] = mk(1, 5'h00, 1, 5'h00, 0, 5'h00, -1);

    // Reset held three cycles with all strobes active.
    reset = 1'b0;
    bus.si = 5'h1F;
    bus.ready = 1'b1;
    for (int i = 0; i < NP; i++) bus.datain[i*PKTW +: PKTW] = {$urandom(), $urandom()};
    repeat (3) begin
      step();
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_so", 64'(bus.so), 64'd0);
      chk("rst_grant", 64'(bus.grant), 64'd0);
      chk("rst_dataout", bus.dataout, 64'd0);
      chk("rst_drop", 64'(bus.drop_cnt), 64'd0);
    end

    // Single packet through port 0.
    reset = 1'b1;
    bus.si = 5'h00;
    step();
    bus.datain[63:0] = 64'h2010DDDDAAAAAAAA;
    bus.si = 5'h01;
    step();
    chk("single_busy_set", 64'(bus.busy), 64'h01);
    chk("single_so_early", 64'(bus.so), 64'd0);
    bus.si = 5'h00;
    step();
    chk("single_so", 64'(bus.so), 64'd1);
    chk("single_grant", 64'(bus.grant), 64'h01);
    chk("single_data", bus.dataout, 64'h2010DDDDAAAAAAAA);
    chk("single_busy_clr", 64'(bus.busy), 64'd0);
    step();
    chk("single_so_end", 64'(bus.so), 64'd0);
    chk("single_grant_end", 64'(bus.grant), 64'd0);

    // Fresh start so round-robin begins at port 0.
    reset = 1'b0;
    step();
    reset = 1'b1;
    load_pkts();
    for (int r = 0; r < 20; r++) begin
      reset = tbl[r].rst_n;
      bus.si = tbl[r].si;
      bus.ready = tbl[r].ready;
      step();
      chk($sformatf("tbl%0d_busy", r), 64'(bus.busy), 64'(tbl[r].x_busy));
      chk($sformatf("tbl%0d_so", r), 64'(bus.so), 64'(tbl[r].x_so));
      chk($sformatf("tbl%0d_grant", r), 64'(bus.grant), 64'(tbl[r].x_grant));
      if (tbl[r].x_so) chk($sformatf("tbl%0d_data", r), bus.dataout, tbl[r].x_data);
    end

    // Drops and saturation on port 2.
    bus.ready = 1'b0;
    bus.si = 5'h04;
    step();
    chk("drop_first_held", 64'(bus.busy), 64'h04);
    chk("drop_none_yet", 64'(bus.drop_cnt), 64'd0);
    step();
    chk("drop_one16", 64'(bus.drop_cnt), 64'd1);
    chk("drop_one2", 64'(bus2.drop_cnt), 64'd1);
    repeat (5) step();
    chk("drop_six16", 64'(bus.drop_cnt), 64'd6);
    chk("drop_sat2", 64'(bus2.drop_cnt), 64'd3);
    bus.ready = 1'b1;
    step();
    chk("drop_grant_so", 64'(bus.so), 64'd1);
    chk("drop_grant_grant", 64'(bus.grant), 64'h04);
    chk("drop_grant_data", bus.dataout, pkt(2));
    chk("drop_grant_cnt", 64'(bus.drop_cnt), 64'd7);
    chk("drop_no_writethru", 64'(bus.busy), 64'd0);
    bus.si = 5'h00;
    step();
    chk("drop_after_so", 64'(bus.so), 64'd0);
    chk("drop_after_hold", bus.dataout, pkt(2));

    // Reset while slots 1 and 3 are held.
    bus.ready = 1'b0;
    bus.si = 5'h0A;
    step();
    chk("midrst_loaded", 64'(bus.busy), 64'h0A);
    bus.si = 5'h00;
    reset = 1'b0;
    step();
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_drop", 64'(bus.drop_cnt), 64'd0);
    reset = 1'b1;
    bus.ready = 1'b1;
    repeat (3) begin
      step();
      chk("midrst_no_stale_so", 64'(bus.so), 64'd0);
      chk("midrst_no_stale_data", bus.dataout, 64'd0);
    end

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 149) != 0);
      bus.si = NP'($urandom_range(0, 31) & $urandom_range(0, 31));
      bus.ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NP; i++) bus.datain[i*PKTW +: PKTW] = {$urandom(), $urandom()};
      step();
    end

    reset = 1'b1;
    bus.si = 5'h00;
    bus.ready = 1'b1;
    repeat (NP + 1) step();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
